// File: rtl/ysyx_22050550_axi_burst_master_pkg.sv
// Shared types and constants for the AXI burst master and its read buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_22050550_axi_burst_master_pkg;

    // Default bus widths.
    localparam int ADDR_W_DFLT = 64;
    localparam int DATA_W_DFLT = 64;
    localparam int LEN_W       = 8;
    localparam int SIZE_W      = 3;
    localparam int BURST_W     = 2;

    // Only INCR bursts are issued.
    localparam logic [BURST_W-1:0] AXI_BURST_INCR = 2'b01;

    // Beat size codes. Codes above 8B are forwarded unchanged.
    localparam logic [SIZE_W-1:0] AXI_SIZE_1B = 3'd0;
    localparam logic [SIZE_W-1:0] AXI_SIZE_2B = 3'd1;
    localparam logic [SIZE_W-1:0] AXI_SIZE_4B = 3'd2;
    localparam logic [SIZE_W-1:0] AXI_SIZE_8B = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4
    } state_e;

    // Burst shape latched at request accept.
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
    } burst_cfg_t;

    // True when the beat counter has reached the final beat of the burst.
    function automatic logic is_last_beat(input logic [LEN_W-1:0] cnt,
                                          input logic [LEN_W-1:0] len);
        return cnt == len;
    endfunction

endpackage

// File: rtl/ysyx_22050550_axi_rbuf.sv
// One-entry holding register for read beats (data + last flag).
// Latency: 1 cycle from input handshake to output valid.
// Backpressure: accepts when empty or when the held beat drains the same cycle.
//
// Ports: clock/reset (async active-low); in_valid_i/in_ready_o/in_data_i/in_last_i
// upstream beat; out_valid_o/out_ready_i/out_data_o/out_last_o downstream beat.
module ysyx_22050550_axi_rbuf
    import ysyx_22050550_axi_burst_master_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);

    logic              vld_q,  vld_d;
    logic [DATA_W-1:0] dat_q,  dat_d;
    logic              last_q, last_d;

    // Pass-through ready: a full buffer can still take a beat while draining.
    assign in_ready_o = !vld_q || out_ready_i;

    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        last_d = last_q;
        if (in_valid_i && in_ready_o) begin
            vld_d  = 1'b1;
            dat_d  = in_data_i;
            last_d = in_last_i;
        end else if (out_ready_i) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            last_q <= last_d;
        end
    end

    assign out_valid_o = vld_q;
    assign out_data_o  = dat_q;
    // Only meaningful while valid; forced low when empty so reset value is 0.
    assign out_last_o  = last_q && vld_q;

endmodule

// File: rtl/ysyx_22050550_axi_burst_master.sv
// AXI-style INCR burst initiator: one client line request -> one read or write burst.
// Latency: address valid the cycle after accept; read beats 1 cycle behind r; done 1 cycle after last beat.
// Backpressure: r stalls when the one-entry buffer is full and not draining; w passes ready straight through.
//
// Ports: clock, reset (async active-low); io_req_* client request; io_wdata_* client
// write beats; io_rdata_* client read beats; io_done completion pulse; io_err sticky
// beat-count error; io_Sram_ar/aw/r/w_* plus io_ar_*/io_aw_* memory-side channels.
// Optional macro YSYX_22050550_AXI_BEAT_CHECK_EN enables the r-last checker driving io_err.
module ysyx_22050550_axi_burst_master
    import ysyx_22050550_axi_burst_master_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic                clock,
    input  logic                reset,
    // client request
    input  logic                io_req_valid,
    output logic                io_req_ready,
    input  logic                io_req_wen,
    input  logic [ADDR_W-1:0]   io_req_addr,
    input  logic [LEN_W-1:0]    io_req_len,
    input  logic [SIZE_W-1:0]   io_req_size,
    // client write beats
    input  logic                io_wdata_valid,
    output logic                io_wdata_ready,
    input  logic [DATA_W-1:0]   io_wdata,
    input  logic [DATA_W/8-1:0] io_wstrb,
    // client read beats
    output logic                io_rdata_valid,
    input  logic                io_rdata_ready,
    output logic [DATA_W-1:0]   io_rdata,
    output logic                io_rdata_last,
    // status
    output logic                io_done,
    output logic                io_err,
    // read address channel
    output logic                io_Sram_ar_valid,
    input  logic                io_Sram_ar_ready,
    output logic [ADDR_W-1:0]   io_Sram_ar_bits_addr,
    output logic [LEN_W-1:0]    io_ar_len,
    output logic [SIZE_W-1:0]   io_ar_size,
    output logic [BURST_W-1:0]  io_ar_burst,
    // read data channel
    input  logic                io_Sram_r_valid,
    output logic                io_Sram_r_ready,
    input  logic [DATA_W-1:0]   io_Sram_r_bits_data,
    input  logic                io_Sram_r_bits_last,
    // write address channel
    output logic                io_Sram_aw_valid,
    input  logic                io_Sram_aw_ready,
    output logic [ADDR_W-1:0]   io_Sram_aw_bits_addr,
    output logic [LEN_W-1:0]    io_aw_len,
    output logic [SIZE_W-1:0]   io_aw_size,
    output logic [BURST_W-1:0]  io_aw_burst,
    // write data channel
    output logic                io_Sram_w_valid,
    input  logic                io_Sram_w_ready,
    output logic [DATA_W-1:0]   io_Sram_w_bits_data,
    output logic [DATA_W/8-1:0] io_Sram_w_bits_strb
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    burst_cfg_t        cfg_q,   cfg_d;
    logic [LEN_W-1:0]  cnt_q,   cnt_d;
    logic              done_q,  done_d;

    logic rbuf_in_vld;
    logic rbuf_in_rdy;
    logic rbuf_out_vld;

    logic req_hs;
    logic r_hs;
    logic w_hs;
    logic beat_last;

    assign req_hs    = io_req_valid && io_req_ready;
    assign r_hs      = io_Sram_r_valid && io_Sram_r_ready;
    assign w_hs      = io_Sram_w_valid && io_Sram_w_ready;
    assign beat_last = is_last_beat(cnt_q, cfg_q.len);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_hs)                state_d = io_req_wen ? ST_AW : ST_AR;
            ST_AR:   if (io_Sram_ar_ready)      state_d = ST_R;
            ST_R:    if (r_hs && beat_last)     state_d = ST_IDLE;
            ST_AW:   if (io_Sram_aw_ready)      state_d = ST_W;
            ST_W:    if (w_hs && beat_last)     state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        io_req_ready     = 1'b0;
        io_Sram_ar_valid = 1'b0;
        io_Sram_aw_valid = 1'b0;
        io_Sram_r_ready  = 1'b0;
        rbuf_in_vld      = 1'b0;
        io_Sram_w_valid  = 1'b0;
        io_wdata_ready   = 1'b0;
        unique case (state_q)
            // A held read beat must drain first, and the done cycle is never
            // an accept cycle. Gating with reset keeps ready low while in reset.
            ST_IDLE: io_req_ready = reset && !rbuf_out_vld && !done_q;
            ST_AR:   io_Sram_ar_valid = 1'b1;
            ST_R: begin
                rbuf_in_vld     = io_Sram_r_valid;
                io_Sram_r_ready = rbuf_in_rdy;
            end
            ST_AW:   io_Sram_aw_valid = 1'b1;
            ST_W: begin
                io_Sram_w_valid = io_wdata_valid;
                io_wdata_ready  = io_Sram_w_ready;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        addr_d = addr_q;
        cfg_d  = cfg_q;
        cnt_d  = cnt_q;
        done_d = (r_hs || w_hs) && beat_last;
        if (req_hs) begin
            addr_d = io_req_addr;
            cfg_d  = '{len: io_req_len, size: io_req_size};
            cnt_d  = '0;
        end else if (r_hs || w_hs) begin
            // len=255 wraps the counter back to 0 on the final beat; harmless.
            cnt_d  = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            cfg_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cfg_q  <= cfg_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    ysyx_22050550_axi_rbuf #(
        .DATA_W (DATA_W)
    ) u_rbuf (
        .clock       (clock),
        .reset       (reset),
        .in_valid_i  (rbuf_in_vld),
        .in_ready_o  (rbuf_in_rdy),
        .in_data_i   (io_Sram_r_bits_data),
        .in_last_i   (beat_last),
        .out_valid_o (rbuf_out_vld),
        .out_ready_i (io_rdata_ready),
        .out_data_o  (io_rdata),
        .out_last_o  (io_rdata_last)
    );

    assign io_rdata_valid       = rbuf_out_vld;
    assign io_done              = done_q;

    assign io_Sram_ar_bits_addr = addr_q;
    assign io_ar_len            = cfg_q.len;
    assign io_ar_size           = cfg_q.size;
    assign io_ar_burst          = AXI_BURST_INCR;

    assign io_Sram_aw_bits_addr = addr_q;
    assign io_aw_len            = cfg_q.len;
    assign io_aw_size           = cfg_q.size;
    assign io_aw_burst          = AXI_BURST_INCR;

    assign io_Sram_w_bits_data  = io_wdata;
    assign io_Sram_w_bits_strb  = io_wstrb;

`ifdef YSYX_22050550_AXI_BEAT_CHECK_EN
    // Responder's last flag must agree with our own count; termination still
    // follows the counter, the flag only records the disagreement.
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (r_hs && (io_Sram_r_bits_last != beat_last)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign io_err = err_q;
`else
    logic unused_r_last;
    assign unused_r_last = io_Sram_r_bits_last;
    assign io_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22050550_axi_burst_master.sv
// Directed bench for the AXI burst master: reads, writes, backpressure, reset abort, beat check.
// Latency: n/a (testbench).
// Backpressure: driven by the directed steps below.
module tb_ysyx_22050550_axi_burst_master;
    import ysyx_22050550_axi_burst_master_pkg::*;

`ifdef YSYX_22050550_AXI_BEAT_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        io_req_valid, io_req_ready, io_req_wen;
    logic [63:0] io_req_addr;
    logic [7:0]  io_req_len;
    logic [2:0]  io_req_size;
    logic        io_wdata_valid, io_wdata_ready;
    logic [63:0] io_wdata;
    logic [7:0]  io_wstrb;
    logic        io_rdata_valid, io_rdata_ready, io_rdata_last;
    logic [63:0] io_rdata;
    logic        io_done, io_err;
    logic        io_Sram_ar_valid, io_Sram_ar_ready;
    logic [63:0] io_Sram_ar_bits_addr;
    logic [7:0]  io_ar_len;
    logic [2:0]  io_ar_size;
    logic [1:0]  io_ar_burst;
    logic        io_Sram_r_valid, io_Sram_r_ready, io_Sram_r_bits_last;
    logic [63:0] io_Sram_r_bits_data;
    logic        io_Sram_aw_valid, io_Sram_aw_ready;
    logic [63:0] io_Sram_aw_bits_addr;
    logic [7:0]  io_aw_len;
    logic [2:0]  io_aw_size;
    logic [1:0]  io_aw_burst;
    logic        io_Sram_w_valid, io_Sram_w_ready;
    logic [63:0] io_Sram_w_bits_data;
    logic [7:0]  io_Sram_w_bits_strb;

    int n_assert = 0;
    int n_fail   = 0;

    ysyx_22050550_axi_burst_master dut (
        .clock                (clock),
        .reset                (reset),
        .io_req_valid         (io_req_valid),
        .io_req_ready         (io_req_ready),
        .io_req_wen           (io_req_wen),
        .io_req_addr          (io_req_addr),
        .io_req_len           (io_req_len),
        .io_req_size          (io_req_size),
        .io_wdata_valid       (io_wdata_valid),
        .io_wdata_ready       (io_wdata_ready),
        .io_wdata             (io_wdata),
        .io_wstrb             (io_wstrb),
        .io_rdata_valid       (io_rdata_valid),
        .io_rdata_ready       (io_rdata_ready),
        .io_rdata             (io_rdata),
        .io_rdata_last        (io_rdata_last),
        .io_done              (io_done),
        .io_err               (io_err),
        .io_Sram_ar_valid     (io_Sram_ar_valid),
        .io_Sram_ar_ready     (io_Sram_ar_ready),
        .io_Sram_ar_bits_addr (io_Sram_ar_bits_addr),
        .io_ar_len            (io_ar_len),
        .io_ar_size           (io_ar_size),
        .io_ar_burst          (io_ar_burst),
        .io_Sram_r_valid      (io_Sram_r_valid),
        .io_Sram_r_ready      (io_Sram_r_ready),
        .io_Sram_r_bits_data  (io_Sram_r_bits_data),
        .io_Sram_r_bits_last  (io_Sram_r_bits_last),
        .io_Sram_aw_valid     (io_Sram_aw_valid),
        .io_Sram_aw_ready     (io_Sram_aw_ready),
        .io_Sram_aw_bits_addr (io_Sram_aw_bits_addr),
        .io_aw_len            (io_aw_len),
        .io_aw_size           (io_aw_size),
        .io_aw_burst          (io_aw_burst),
        .io_Sram_w_valid      (io_Sram_w_valid),
        .io_Sram_w_ready      (io_Sram_w_ready),
        .io_Sram_w_bits_data  (io_Sram_w_bits_data),
        .io_Sram_w_bits_strb  (io_Sram_w_bits_strb)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Issue a request and complete its address phase after 'delay' stall cycles.
    task automatic do_req(input logic wen, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input int delay, input string tag);
        io_req_valid = 1'b1;
        io_req_wen   = wen;
        io_req_addr  = addr;
        io_req_len   = len;
        io_req_size  = size;
        #1;
        chk({tag, "_req_ready"}, io_req_ready, 1'b1);
        cyc();
        io_req_valid = 1'b0;
        for (int d = 0; d <= delay; d++) begin
            #1;
            chk({tag, "_req_ready_busy"}, io_req_ready, 1'b0);
            if (wen) begin
                chk({tag, "_aw_valid"}, io_Sram_aw_valid, 1'b1);
                chk({tag, "_ar_valid"}, io_Sram_ar_valid, 1'b0);
                chk({tag, "_aw_addr"},  io_Sram_aw_bits_addr, addr);
                chk({tag, "_aw_len"},   io_aw_len, len);
                chk({tag, "_aw_size"},  io_aw_size, size);
                chk({tag, "_aw_burst"}, io_aw_burst, 2'b01);
            end else begin
                chk({tag, "_ar_valid"}, io_Sram_ar_valid, 1'b1);
                chk({tag, "_aw_valid"}, io_Sram_aw_valid, 1'b0);
                chk({tag, "_ar_addr"},  io_Sram_ar_bits_addr, addr);
                chk({tag, "_ar_len"},   io_ar_len, len);
                chk({tag, "_ar_size"},  io_ar_size, size);
                chk({tag, "_ar_burst"}, io_ar_burst, 2'b01);
            end
            if (d == delay) begin
                io_Sram_ar_ready = 1'b1;
                io_Sram_aw_ready = 1'b1;
            end
            cyc();
        end
        io_Sram_ar_ready = 1'b0;
        io_Sram_aw_ready = 1'b0;
        #1;
        chk({tag, "_addr_drop"}, {io_Sram_ar_valid, io_Sram_aw_valid}, 2'b00);
    endtask

    // Feed len+1 read beats base+step*i with the client always ready.
    // bad_idx >= 0 forces the responder's last flag high on that beat.
    task automatic run_read(input logic [7:0] len, input logic [63:0] base,
                            input logic [63:0] step, input int bad_idx, input string tag);
        for (int i = 0; i <= int'(len); i++) begin
            io_rdata_ready      = 1'b1;
            io_Sram_r_valid     = 1'b1;
            io_Sram_r_bits_data = base + step * 64'(i);
            io_Sram_r_bits_last = (i == int'(len)) || (i == bad_idx);
            #1;
            chk({tag, "_r_ready"}, io_Sram_r_ready, 1'b1);
            chk({tag, "_done_mid"}, io_done, 1'b0);
            chk({tag, "_rvalid"}, io_rdata_valid, i > 0);
            chk({tag, "_err_mid"}, io_err, CHK_EN && (bad_idx >= 0) && (i > bad_idx));
            if (i > 0) begin
                chk({tag, "_rdata"}, io_rdata, base + step * 64'(i - 1));
                chk({tag, "_rlast_mid"}, io_rdata_last, 1'b0);
            end
            cyc();
        end
        io_Sram_r_valid     = 1'b0;
        io_Sram_r_bits_last = 1'b0;
        #1;
        chk({tag, "_rvalid_end"}, io_rdata_valid, 1'b1);
        chk({tag, "_rdata_end"}, io_rdata, base + step * 64'(len));
        chk({tag, "_rlast_end"}, io_rdata_last, 1'b1);
        chk({tag, "_done"}, io_done, 1'b1);
        chk({tag, "_req_ready_done"}, io_req_ready, 1'b0);
        chk({tag, "_r_ready_idle"}, io_Sram_r_ready, 1'b0);
        cyc();
        #1;
        chk({tag, "_done_off"}, io_done, 1'b0);
        chk({tag, "_rvalid_off"}, io_rdata_valid, 1'b0);
        chk({tag, "_req_ready_idle"}, io_req_ready, 1'b1);
    endtask

    int          sent, recv;
    logic        mvalid, done_exp, exp_rr, hs, consume;
    logic [63:0] mdata;

    initial begin
        reset = 1'b0;
        io_req_valid = 1'b0; io_req_wen = 1'b0; io_req_addr = '0; io_req_len = '0; io_req_size = '0;
        io_wdata_valid = 1'b0; io_wdata = '0; io_wstrb = '0; io_rdata_ready = 1'b0;
        io_Sram_ar_ready = 1'b0; io_Sram_aw_ready = 1'b0; io_Sram_w_ready = 1'b0;
        io_Sram_r_valid = 1'b0; io_Sram_r_bits_data = '0; io_Sram_r_bits_last = 1'b0;

        // ---------------- reset values
        cyc(); cyc();
        chk("rst_req_ready", io_req_ready, 1'b0);
        chk("rst_valids", {io_Sram_ar_valid, io_Sram_aw_valid, io_Sram_w_valid, io_rdata_valid}, 4'b0);
        chk("rst_readies", {io_Sram_r_ready, io_wdata_ready}, 2'b0);
        chk("rst_status", {io_done, io_err, io_rdata_last}, 3'b0);
        chk("rst_ar_addr", io_Sram_ar_bits_addr, 64'h0);
        chk("rst_len_size", {io_ar_len, io_ar_size, io_aw_len, io_aw_size}, 22'h0);
        reset = 1'b1;
        #1;
        chk("rst_release_req_ready", io_req_ready, 1'b1);
        cyc();

        // ---------------- T1: read len=3, 8-byte beats
        do_req(1'b0, 64'h8000_0000, 8'd3, AXI_SIZE_8B, 0, "t1");
        run_read(8'd3, 64'h11, 64'h11, -1, "t1");

        // ---------------- T2: single write beat
        do_req(1'b1, 64'h8000_1000, 8'd0, AXI_SIZE_4B, 0, "t2");
        io_wdata_valid = 1'b1; io_wdata = 64'hDEAD_BEEF; io_wstrb = 8'h0F; io_Sram_w_ready = 1'b1;
        #1;
        chk("t2_w_valid", io_Sram_w_valid, 1'b1);
        chk("t2_w_data", io_Sram_w_bits_data, 64'hDEAD_BEEF);
        chk("t2_w_strb", io_Sram_w_bits_strb, 8'h0F);
        chk("t2_wdata_ready", io_wdata_ready, 1'b1);
        chk("t2_done_early", io_done, 1'b0);
        cyc();
        io_wdata_valid = 1'b0;
        #1;
        chk("t2_done", io_done, 1'b1);
        chk("t2_w_valid_off", io_Sram_w_valid, 1'b0);
        chk("t2_req_ready_done", io_req_ready, 1'b0);
        cyc();
        chk("t2_done_off", io_done, 1'b0);
        chk("t2_req_ready_idle", io_req_ready, 1'b1);

        // ---------------- T3: read len=7, client ready toggles
        do_req(1'b0, 64'h8000_2000, 8'd7, AXI_SIZE_8B, 0, "t3");
        sent = 0; recv = 0; mvalid = 1'b0; mdata = '0; done_exp = 1'b0;
        for (int k = 0; k < 80 && recv < 8; k++) begin
            io_rdata_ready      = (k % 2 == 1);
            io_Sram_r_valid     = (sent < 8);
            io_Sram_r_bits_data = 64'h100 + 64'(sent);
            io_Sram_r_bits_last = (sent == 7);
            #1;
            exp_rr = (sent < 8) && (!mvalid || io_rdata_ready);
            chk("t3_r_ready", io_Sram_r_ready, exp_rr);
            chk("t3_rvalid", io_rdata_valid, mvalid);
            chk("t3_done", io_done, done_exp);
            if (mvalid) begin
                chk("t3_rdata", io_rdata, mdata);
                chk("t3_rlast", io_rdata_last, mdata == 64'h107);
            end
            consume  = mvalid && io_rdata_ready;
            hs       = exp_rr && (sent < 8);
            done_exp = hs && (sent == 7);
            if (consume) recv++;
            if (hs) begin
                mdata  = 64'h100 + 64'(sent);
                mvalid = 1'b1;
                sent++;
            end else if (consume) begin
                mvalid = 1'b0;
            end
            cyc();
        end
        io_Sram_r_valid = 1'b0; io_Sram_r_bits_last = 1'b0; io_rdata_ready = 1'b0;
        #1;
        chk("t3_rvalid_end", io_rdata_valid, 1'b0);
        chk("t3_req_ready_idle", io_req_ready, recv == 8);

        // ---------------- T4: write len=3, aw stalled 5 cycles, gapped data
        do_req(1'b1, 64'h8000_3000, 8'd3, AXI_SIZE_8B, 5, "t4");
        sent = 0;
        for (int k = 0; k < 40 && sent < 4; k++) begin
            io_wdata_valid  = (k % 2 == 0);
            io_wdata        = 64'hA0 + 64'(sent);
            io_wstrb        = 8'hF0 | 8'(sent);
            io_Sram_w_ready = (k != 2);
            #1;
            chk("t4_w_valid", io_Sram_w_valid, io_wdata_valid);
            chk("t4_wdata_ready", io_wdata_ready, io_Sram_w_ready);
            chk("t4_done_early", io_done, 1'b0);
            if (io_wdata_valid) begin
                chk("t4_w_data", io_Sram_w_bits_data, 64'hA0 + 64'(sent));
                chk("t4_w_strb", io_Sram_w_bits_strb, 8'hF0 | 8'(sent));
            end
            if (io_wdata_valid && io_Sram_w_ready) sent++;
            cyc();
        end
        io_wdata_valid = 1'b1;
        #1;
        chk("t4_done", io_done, 1'b1);
        chk("t4_no_extra_beat", io_Sram_w_valid, 1'b0);
        chk("t4_wdata_ready_idle", io_wdata_ready, 1'b0);
        io_wdata_valid = 1'b0;
        cyc();
        chk("t4_req_ready_idle", io_req_ready, 1'b1);
        chk("t4_done_off", io_done, 1'b0);

        // ---------------- T5: reset during the second beat of a len=3 read
        do_req(1'b0, 64'h8000_4000, 8'd3, AXI_SIZE_8B, 0, "t5");
        io_rdata_ready = 1'b0;
        io_Sram_r_valid = 1'b1; io_Sram_r_bits_data = 64'h1; io_Sram_r_bits_last = 1'b0;
        cyc();
        io_Sram_r_bits_data = 64'h2;
        #1;
        chk("t5_rvalid_pre", io_rdata_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("t5_abort_r_ready", io_Sram_r_ready, 1'b0);
        chk("t5_abort_rvalid", io_rdata_valid, 1'b0);
        chk("t5_abort_rdata", io_rdata, 64'h0);
        chk("t5_abort_req_ready", io_req_ready, 1'b0);
        chk("t5_abort_ar", {io_Sram_ar_bits_addr, io_ar_len, io_ar_size}, 75'h0);
        chk("t5_abort_status", {io_done, io_err, io_rdata_last}, 3'b0);
        cyc();
        chk("t5_held_r_ready", io_Sram_r_ready, 1'b0);
        io_Sram_r_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5_release_req_ready", io_req_ready, 1'b1);
        cyc();
        do_req(1'b0, 64'h8000_5000, 8'd0, AXI_SIZE_1B, 0, "t5b");
        run_read(8'd0, 64'h55, 64'h0, -1, "t5b");
        do_req(1'b0, 64'h8000_5008, 8'd1, AXI_SIZE_2B, 2, "t5c");
        run_read(8'd1, 64'h66, 64'h1, -1, "t5c");

        // ---------------- T6: responder flags last early on beat 2 of a len=3 read
        do_req(1'b0, 64'h8000_6000, 8'd3, AXI_SIZE_8B, 0, "t6");
        run_read(8'd3, 64'h200, 64'h1, 2, "t6");
        chk("t6_err", io_err, CHK_EN);
        cyc(); cyc(); cyc();
        chk("t6_err_sticky", io_err, CHK_EN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050550_axi_burst_master.md
# ysyx_22050550_axi_burst_master

AXI-style burst initiator that turns single cache-side line requests into INCR read or write bursts toward the `io_Sram_*` memory responder. It sits between the cache refill/writeback logic and the memory port, drives the ar/aw/w channels, consumes r beats through a one-entry output buffer, and signals completion to the client. There is no b channel: a write completes when its last w beat is accepted.

## Interface
Parameters:
- `ADDR_W`, 64, address width.
- `DATA_W`, 64, beat width (strobe width is `DATA_W/8`).

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `io_req_valid` in 1, `io_req_ready` out 1: request handshake.
- `io_req_wen` in 1: 1 = write burst, 0 = read burst.
- `io_req_addr` in 64, `io_req_len` in 8, `io_req_size` in 3: start address, beats−1, beat size code.
- `io_wdata_valid` in 1, `io_wdata_ready` out 1, `io_wdata` in 64, `io_wstrb` in 8: client write-beat stream.
- `io_rdata_valid` out 1, `io_rdata_ready` in 1, `io_rdata` out 64, `io_rdata_last` out 1: client read-beat stream.
- `io_done` out 1: one-cycle completion pulse.
- `io_err` out 1: sticky protocol-error flag (only with the macro; tied 0 otherwise).
- `io_Sram_ar_valid` out 1, `io_Sram_ar_ready` in 1, `io_Sram_ar_bits_addr` out 64, `io_ar_len` out 8, `io_ar_size` out 3, `io_ar_burst` out 2.
- `io_Sram_r_valid` in 1, `io_Sram_r_ready` out 1, `io_Sram_r_bits_data` in 64, `io_Sram_r_bits_last` in 1.
- `io_Sram_aw_valid` out 1, `io_Sram_aw_ready` in 1, `io_Sram_aw_bits_addr` out 64, `io_aw_len` out 8, `io_aw_size` out 3, `io_aw_burst` out 2.
- `io_Sram_w_valid` out 1, `io_Sram_w_ready` in 1, `io_Sram_w_bits_data` out 64, `io_Sram_w_bits_strb` out 8.

## Operation
- States: IDLE, AR, R, AW, W.
- IDLE: `io_req_ready` = 1 while the read buffer is empty. On accept, latch addr/len/size, clear beat counter, go to AR (read) or AW (write).
- AR/AW: assert `ar_valid`/`aw_valid` with the latched fields; `burst` is constant 2'b01 (INCR). The fields stay stable until `ready`; then go to R/W.
- R: `io_Sram_r_ready` = !rbuf_valid || `io_rdata_ready`. Each r handshake loads the buffer (data, last = counter==len) and increments the counter. The handshake with counter==len returns to IDLE.
- W: `io_Sram_w_valid` = `io_wdata_valid`, `io_wdata_ready` = `io_Sram_w_ready`, with data and strobe passed through combinationally. Each w handshake increments the counter; the one with counter==len returns to IDLE.
- `io_done`: registered pulse, high the cycle after the final r or w handshake.
- Counter is 8 bits. len=255 gives 256 beats, and the counter wraps to 0 harmlessly.
- Size codes ≥3 are forwarded unchanged, and the responder treats them as 8-byte beats.

## Timing
- Reset values: every valid/ready output 0; `io_done`, `io_err` and `io_rdata_last` 0; address/len/size outputs 0; state IDLE; rbuf empty. Exception: `io_req_ready` = 1 once reset deasserts.
- Request accepted at edge N gives `ar_valid`/`aw_valid` high in cycle N+1. Minimum address phase is 1 cycle.
- Read data is visible on `io_rdata` one cycle after its r handshake and held until `io_rdata_ready`.
- A new request cannot be accepted in the same cycle as `io_done`. It can be accepted the following cycle, provided the read buffer is empty.
- An asynchronous reset mid-burst aborts immediately to the reset values. No further beats are issued or accepted.

## Configuration
- `YSYX_22050550_AXI_BEAT_CHECK_EN`.
- Defined: on every r handshake, compare `io_Sram_r_bits_last` with (counter==len). A mismatch sets `io_err`, which stays set until reset. Termination still follows the counter.
- Undefined: no checker, and `io_err` is constant 0.

## Structure
- Shared package holds:
  - state encoding;
  - `AXI_BURST_INCR` = 2'b01;
  - size codes 0–3;
  - width constants.
- Sub-module `ysyx_22050550_axi_rbuf`: one-entry data/last holding register with valid/ready on both sides, used for the r path.

## Test plan
- Read, len=3, size=3, addr 0x8000_0000, responder returning 0x11/0x22/0x33/0x44 → one AR with len 3, burst 1; four beats out in order; `io_rdata_last` on 0x44; `io_done` pulses once.
- Single write, len=0, data 0xDEAD_BEEF, strb 0x0F → one AW, one W beat with matching data and strb; `io_done` the cycle after the w handshake.
- Read, len=7, with `io_rdata_ready` toggling every other cycle → no beat lost or duplicated; `io_Sram_r_ready` low whenever the buffer is full and not draining.
- Write, len=3, `ar_ready`/`aw_ready` delayed 5 cycles and `io_wdata_valid` gapped → aw fields stable while waiting; exactly 4 beats; return to IDLE.
- Assert reset in the second beat of a len=3 read → all outputs at reset values immediately; a following request runs normally.
- With the macro defined, responder asserts last on beat 2 of a len=3 read → `io_err` goes high and stays high; the burst still completes after 4 beats.
